// File: rtl/overvoltage_pkg.sv
// Shared types and constants for the overvoltage comparator controller.
package overvoltage_pkg;

  localparam int unsigned OTRIP_W = 4;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 64;

  typedef enum logic [1:0] {
    StOff     = 2'b00,
    StSettle  = 2'b01,
    StMonitor = 2'b10,
    StTripped = 2'b11
  } ov_state_e;

endpackage

// File: rtl/ov_sync.sv
// Async-reset flop chain for bringing an analog-domain level into the clk domain.
module ov_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/overvoltage_monitor_ctrl.sv
// Enables/trims the overvoltage comparator, blanks its settling window and debounces its output
// into a level flag, a sticky status bit and an interrupt.
module overvoltage_monitor_ctrl
  import overvoltage_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int unsigned DEB_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic [OTRIP_W-1:0] otrip_cfg,
  input  logic [DEB_W-1:0]   deb_cfg,
  input  logic               irq_clr,
  input  logic               ovout,
  output logic               ena,
  output logic [OTRIP_W-1:0] otrip,
  output logic               ov_flag,
  output logic               ov_sticky,
  output logic               irq,
  output logic [1:0]         state_o
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);

  ov_state_e          state_q;
  logic               ena_q;
  logic [OTRIP_W-1:0] otrip_q;
  logic               flag_q;
  logic               sticky_q;
  logic [SettleW-1:0] settle_q;
  logic [DEB_W-1:0]   deb_q;

  logic               ov_synced;
  logic [DEB_W-1:0]   deb_thr;
  logic [DEB_W:0]     deb_inc;
  logic [DEB_W-1:0]   deb_sat;
  logic               deb_hit;
  logic               deb_sample;
  logic               otrip_chg;

  ov_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ov_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ovout),
    .q    (ov_synced)
  );

  assign deb_thr    = (deb_cfg == '0) ? DEB_W'(1) : deb_cfg;
  assign deb_inc    = {1'b0, deb_q} + (DEB_W + 1)'(1);
  assign deb_sat    = (&deb_q) ? deb_q : deb_inc[DEB_W-1:0];
  // Compare the count including the current sample, so the flag moves on the Nth sample's edge.
  assign deb_hit    = deb_inc >= {1'b0, deb_thr};
  // MONITOR counts synced-high samples, TRIPPED counts synced-low samples.
  assign deb_sample = ov_synced ^ (state_q == StTripped);
  assign otrip_chg  = otrip_cfg != otrip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      ena_q    <= 1'b0;
      otrip_q  <= '0;
      flag_q   <= 1'b0;
      sticky_q <= 1'b0;
      settle_q <= '0;
      deb_q    <= '0;
    end else begin
      // A flag rise later in this block overrides the clear.
      if (irq_clr) sticky_q <= 1'b0;
      if (!en_req) begin
        state_q  <= StOff;
        ena_q    <= 1'b0;
        flag_q   <= 1'b0;
        settle_q <= '0;
        deb_q    <= '0;
      end else begin
        unique case (state_q)
          StOff: begin
            state_q  <= StSettle;
            ena_q    <= 1'b1;
            otrip_q  <= otrip_cfg;
            settle_q <= SettleLoad;
            deb_q    <= '0;
          end
          StSettle: begin
            deb_q <= '0;
            if (otrip_chg) begin
              otrip_q  <= otrip_cfg;
              settle_q <= SettleLoad;
            end else if (settle_q == '0) begin
              state_q <= StMonitor;
            end else begin
              settle_q <= settle_q - SettleW'(1);
            end
          end
          StMonitor, StTripped: begin
            if (otrip_chg) begin
              state_q  <= StSettle;
              otrip_q  <= otrip_cfg;
              flag_q   <= 1'b0;
              settle_q <= SettleLoad;
              deb_q    <= '0;
            end else if (!deb_sample) begin
              deb_q <= '0;
            end else if (deb_hit) begin
              deb_q <= '0;
              if (state_q == StMonitor) begin
                state_q  <= StTripped;
                flag_q   <= 1'b1;
                sticky_q <= 1'b1;
              end else begin
                state_q <= StMonitor;
                flag_q  <= 1'b0;
              end
            end else begin
              deb_q <= deb_sat;
            end
          end
        endcase
      end
    end
  end

  assign ena       = ena_q;
  assign otrip     = otrip_q;
  assign ov_flag   = flag_q;
  assign ov_sticky = sticky_q;
  assign irq       = sticky_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_overvoltage_monitor_ctrl.sv
// Directed bench for overvoltage_monitor_ctrl; expected output vectors go through a scoreboard.
module tb_overvoltage_monitor_ctrl;
  import overvoltage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_req = 1'b0;
  logic [3:0] otrip_cfg = 4'h0;
  logic [7:0] deb_cfg = 8'd4;
  logic       irq_clr = 1'b0;
  logic       ovout = 1'b0;
  logic       ena;
  logic [3:0] otrip;
  logic       ov_flag;
  logic       ov_sticky;
  logic       irq;
  logic [1:0] state_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];

  overvoltage_monitor_ctrl #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(64),
    .DEB_W        (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_req   (en_req),
    .otrip_cfg(otrip_cfg),
    .deb_cfg  (deb_cfg),
    .irq_clr  (irq_clr),
    .ovout    (ovout),
    .ena      (ena),
    .otrip    (otrip),
    .ov_flag  (ov_flag),
    .ov_sticky(ov_sticky),
    .irq      (irq),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Vector layout: {ena, otrip, ov_flag, ov_sticky, irq, state}; irq always mirrors sticky.
  task automatic push(input string tag, input logic e, input logic [3:0] ot, input logic f,
                      input logic s, input logic [1:0] st);
    exp_t x;
    x.tag = tag;
    x.exp = {e, ot, f, s, s, st};
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t       x;
    logic [9:0] obs;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    x   = sb.pop_front();
    obs = {ena, otrip, ov_flag, ov_sticky, irq, state_o};
    assert (obs === x.exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_after(input int n, input string tag, input logic e, input logic [3:0] ot,
                              input logic f, input logic s, input logic [1:0] st);
    push(tag, e, ot, f, s, st);
    step(n);
    pop_check();
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    expect_after(0, "reset", 1'b0, 4'h0, 1'b0, 1'b0, StOff);
    rst_n = 1'b1;
    step(1);
    expect_after(1, "off_idle", 1'b0, 4'h0, 1'b0, 1'b0, StOff);

    // Enable with ovout high throughout most of the settle window.
    en_req = 1'b1; otrip_cfg = 4'hA; deb_cfg = 8'd4; ovout = 1'b1;
    expect_after(1, "t1_enable", 1'b1, 4'hA, 1'b0, 1'b0, StSettle);
    expect_after(62, "t1_settle_blank", 1'b1, 4'hA, 1'b0, 1'b0, StSettle);
    ovout = 1'b0;
    expect_after(1, "t1_settle_edge64", 1'b1, 4'hA, 1'b0, 1'b0, StSettle);
    expect_after(1, "t1_monitor_edge65", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    step(3);

    ovout = 1'b1;
    expect_after(5, "t2_pre_trip", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    expect_after(1, "t2_trip", 1'b1, 4'hA, 1'b1, 1'b1, StTripped);

    ovout = 1'b0;
    expect_after(5, "t4_hold", 1'b1, 4'hA, 1'b1, 1'b1, StTripped);
    expect_after(1, "t4_release", 1'b1, 4'hA, 1'b0, 1'b1, StMonitor);
    irq_clr = 1'b1;
    expect_after(1, "t4_clear", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    irq_clr = 1'b0;
    ovout = 1'b1;
    expect_after(5, "t4_pre_rise", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    irq_clr = 1'b1;
    expect_after(1, "t4_set_wins", 1'b1, 4'hA, 1'b1, 1'b1, StTripped);
    irq_clr = 1'b0;
    ovout = 1'b0;
    expect_after(6, "t4_release2", 1'b1, 4'hA, 1'b0, 1'b1, StMonitor);
    irq_clr = 1'b1;
    expect_after(1, "t4_late_clear", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    expect_after(1, "t4_clr_noop", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    irq_clr = 1'b0;

    // Three-high glitches never reach a count of four.
    for (int i = 0; i < 4; i++) begin
      ovout = 1'b1;
      step(3);
      ovout = 1'b0;
      step(1);
    end
    expect_after(3, "t3_glitch_reject", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    deb_cfg = 8'd0;
    ovout = 1'b1;
    step(1);
    ovout = 1'b0;
    expect_after(1, "t3_deb0_edge2", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    expect_after(1, "t3_deb0_trip", 1'b1, 4'hA, 1'b1, 1'b1, StTripped);
    expect_after(1, "t3_deb0_release", 1'b1, 4'hA, 1'b0, 1'b1, StMonitor);
    deb_cfg = 8'd4;
    irq_clr = 1'b1;
    expect_after(1, "t3_clear", 1'b1, 4'hA, 1'b0, 1'b0, StMonitor);
    irq_clr = 1'b0;

    otrip_cfg = 4'h3;
    expect_after(1, "t5_retrim", 1'b1, 4'h3, 1'b0, 1'b0, StSettle);
    expect_after(63, "t5_settle_end", 1'b1, 4'h3, 1'b0, 1'b0, StSettle);
    expect_after(1, "t5_monitor", 1'b1, 4'h3, 1'b0, 1'b0, StMonitor);

    ovout = 1'b1;
    expect_after(6, "t6_trip", 1'b1, 4'h3, 1'b1, 1'b1, StTripped);
    en_req = 1'b0;
    expect_after(1, "t6_off", 1'b0, 4'h3, 1'b0, 1'b1, StOff);
    ovout = 1'b0; en_req = 1'b1; otrip_cfg = 4'h5;
    expect_after(1, "t6_reenable", 1'b1, 4'h5, 1'b0, 1'b1, StSettle);
    step(10);
    #2 rst_n = 1'b0;
    expect_after(0, "t6_async_reset", 1'b0, 4'h0, 1'b0, 1'b0, StOff);
    en_req = 1'b0;
    step(1);
    rst_n = 1'b1;
    expect_after(1, "t6_post_reset", 1'b0, 4'h0, 1'b0, 1'b0, StOff);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
